// File: rtl/qspi_flash_responder_if.sv
// rtl/qspi_flash_responder_if.sv - SPI pins and byte memory port of the flash responder
interface qspi_flash_responder_if #(
   parameter int ADDR_W = 24
);
   logic              sck;
   logic              ss_n;
   logic              mosi;
   logic              miso_o;
   logic              miso_t;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              busy;

   modport slave (
      input  sck, ss_n, mosi, mem_rdata,
      output miso_o, miso_t, mem_rd, mem_addr, busy
   );

   modport master (
      output sck, ss_n, mosi, mem_rdata,
      input  miso_o, miso_t, mem_rd, mem_addr, busy
   );
endinterface

// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - mode-0 serial flash target serving READ, READ ID and READ STATUS
module qspi_flash_responder #(
   parameter int          ADDR_W   = 24,
   parameter logic [23:0] JEDEC_ID = 24'hEF4018,
   parameter logic [7:0]  STATUS   = 8'h00
) (
   input  logic                  clk,
   input  logic                  resetn,
   qspi_flash_responder_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_STAT, S_IGNORE
   } state_t;

   state_t            state;
   logic [2:0]        sck_s;
   logic [1:0]        ss_s;
   logic [1:0]        mosi_s;
   logic [1:0]        sync_ok;
   logic              armed;
   logic [23:0]       in_sh;
   logic [4:0]        bit_cnt;
   logic [2:0]        b;
   logic [7:0]        out_sh;
   logic [7:0]        byte_buf;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        id_idx;
   logic              rd_pend;
   logic              miso_t_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] mem_addr_q;

   logic              sck_rise;
   logic              sck_fall;
   logic              ss_high;
   logic [23:0]       in_next;
   logic [ADDR_W-1:0] addr_inc;

   assign sck_rise = sck_s[1] & ~sck_s[2];
   assign sck_fall = ~sck_s[1] & sck_s[2];
   assign ss_high  = ss_s[1];
   assign in_next  = {in_sh[22:0], mosi_s[1]};
   assign addr_inc = addr + ADDR_W'(1);

   assign bus.miso_o   = out_sh[7];
   assign bus.miso_t   = miso_t_q;
   assign bus.mem_rd   = mem_rd_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.busy     = ~ss_high;

   function automatic logic [7:0] id_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return JEDEC_ID[23:16];
         2'd1:    return JEDEC_ID[15:8];
         default: return JEDEC_ID[7:0];
      endcase
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         sck_s      <= '0;
         ss_s       <= 2'b11;
         mosi_s     <= '0;
         sync_ok    <= '0;
         armed      <= 1'b0;
         in_sh      <= '0;
         bit_cnt    <= '0;
         b          <= '0;
         out_sh     <= '0;
         byte_buf   <= '0;
         addr       <= '0;
         id_idx     <= '0;
         rd_pend    <= 1'b0;
         miso_t_q   <= 1'b1;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         sck_s    <= {sck_s[1:0], bus.sck};
         ss_s     <= {ss_s[0], bus.ss_n};
         mosi_s   <= {mosi_s[0], bus.mosi};
         sync_ok  <= {sync_ok[0], 1'b1};
         mem_rd_q <= 1'b0;
         rd_pend  <= mem_rd_q & ~ss_high;

         if (rd_pend && state == S_DATA && !ss_high)
            byte_buf <= bus.mem_rdata;

         // A transfer only starts after ss_n has been seen high through a refilled synchronizer
         if (ss_high) begin
            state    <= S_IDLE;
            miso_t_q <= 1'b1;
            out_sh   <= '0;
            armed    <= sync_ok[1];
         end else begin
            case (state)
               S_IDLE: begin
                  if (armed) begin
                     state   <= S_CMD;
                     armed   <= 1'b0;
                     bit_cnt <= '0;
                     b       <= '0;
                  end
               end
               S_CMD: begin
                  if (sck_rise) begin
                     in_sh   <= in_next;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        case (in_next[7:0])
                           8'h03: state <= S_ADDR;
                           8'h9F: begin
                              state    <= S_ID;
                              byte_buf <= JEDEC_ID[23:16];
                              id_idx   <= 2'd1;
                           end
                           8'h05: begin
                              state    <= S_STAT;
                              byte_buf <= STATUS;
                           end
                           default: state <= S_IGNORE;
                        endcase
                     end
                  end
               end
               S_ADDR: begin
                  if (sck_rise) begin
                     in_sh   <= in_next;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd23) begin
                        state      <= S_DATA;
                        addr       <= ADDR_W'(in_next);
                        mem_addr_q <= ADDR_W'(in_next);
                        mem_rd_q   <= 1'b1;
                     end
                  end
               end
               S_DATA, S_ID, S_STAT: begin
                  if (sck_fall) begin
                     miso_t_q <= 1'b0;
                     b        <= b + 3'd1;
                     if (b == 3'd0) begin
                        out_sh <= byte_buf;
                        // Prefetch the following byte a whole byte-time ahead of its load
                        if (state == S_DATA) begin
                           addr       <= addr_inc;
                           mem_addr_q <= addr_inc;
                           mem_rd_q   <= 1'b1;
                        end else if (state == S_ID) begin
                           byte_buf <= id_byte(id_idx);
                           id_idx   <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                        end
                     end else begin
                        out_sh <= {out_sh[6:0], 1'b0};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
